// File: rtl/axis_key_unlocker.sv
// Gated AXIS byte pass-through that opens when any of several magic keys is seen on the stream
// and closes again on a lock sequence, an idle timeout or an external force_lock.
module axis_key_unlocker #(
    parameter int MAGIC_BYTES = 15,
    parameter int NUM_KEYS = 2,
    parameter logic [NUM_KEYS*MAGIC_BYTES*8-1:0] KEYS = {"#!manilakey01!#", "#!manilamagic!#"},
    parameter logic [MAGIC_BYTES*8-1:0] LOCK_KEY = "#!manilalock!!#",
    parameter int TIMEOUT_CYCLES = 0,
    localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic             clk,
    input  logic             sresetn,
    output logic             s_axis_tready,
    input  logic             s_axis_tvalid,
    input  logic [7:0]       s_axis_tdata,
    input  logic             m_axis_tready,
    output logic             m_axis_tvalid,
    output logic [7:0]       m_axis_tdata,
    input  logic             force_lock,
    output logic             unlocked,
    output logic [KEY_W-1:0] key_idx,
    output logic             unlock_pulse,
    output logic             lock_pulse
);

    localparam int KEY_BITS  = MAGIC_BYTES * 8;
    localparam int HIST_BITS = (MAGIC_BYTES > 1) ? (MAGIC_BYTES - 1) * 8 : 8;
    localparam int FILL_W    = $clog2(MAGIC_BYTES + 1);
    localparam int IDLE_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {
        ST_LOCKED   = 1'b0,
        ST_UNLOCKED = 1'b1
    } state_t;

    state_t               state;
    logic                 accept;
    logic [KEY_BITS-1:0]  window;
    logic [HIST_BITS-1:0] history;
    logic [HIST_BITS-1:0] history_shift;
    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    fill_next;
    logic                 window_full;
    logic                 key_hit;
    logic [KEY_W-1:0]     key_sel;
    logic                 lock_hit;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [IDLE_W-1:0]    idle_next;
    logic                 timeout_hit;
    logic                 lock_event;
    logic                 unlock_event;

    assign unlocked      = (state == ST_UNLOCKED);
    assign s_axis_tready = unlocked ? m_axis_tready : 1'b1;
    assign m_axis_tvalid = unlocked & s_axis_tvalid;
    assign m_axis_tdata  = unlocked ? s_axis_tdata : 8'h00;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // The stored history holds the previous MAGIC_BYTES-1 bytes; the incoming byte completes the
    // window, so matching happens on the post-shift view and overlapping prefixes still match.
    generate
        if (MAGIC_BYTES > 1) begin : g_multi
            assign window        = {history, s_axis_tdata};
            assign history_shift = window[KEY_BITS-9:0];
        end else begin : g_single
            assign window        = s_axis_tdata;
            assign history_shift = history;
        end
    endgenerate

    always_comb begin
        fill_next   = (fill == FILL_W'(MAGIC_BYTES)) ? fill : fill + 1'b1;
        window_full = (fill_next == FILL_W'(MAGIC_BYTES));
    end

    // Scanning from the highest index down lets the lowest matching key win.
    always_comb begin
        key_hit = 1'b0;
        key_sel = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (window == KEYS[k*KEY_BITS +: KEY_BITS]) begin
                key_hit = 1'b1;
                key_sel = KEY_W'(k);
            end
        end
        key_hit = key_hit & accept & window_full;
    end

    assign lock_hit = accept & window_full & (window == LOCK_KEY);

    always_comb begin
        idle_next   = '0;
        timeout_hit = 1'b0;
        if ((TIMEOUT_CYCLES > 0) && unlocked && !accept) begin
            idle_next   = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;
            timeout_hit = (idle_next == IDLE_W'(TIMEOUT_CYCLES));
        end
    end

    assign lock_event   = unlocked & (force_lock | lock_hit | timeout_hit);
    assign unlock_event = !unlocked & !force_lock & key_hit;

    // Any transition clears the history, so a new key or lock sequence must always be sent whole.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state        <= ST_LOCKED;
            key_idx      <= '0;
            unlock_pulse <= 1'b0;
            lock_pulse   <= 1'b0;
            history      <= '0;
            fill         <= '0;
            idle_cnt     <= '0;
        end else begin
            unlock_pulse <= 1'b0;
            lock_pulse   <= 1'b0;
            idle_cnt     <= idle_next;
            if (lock_event) begin
                state      <= ST_LOCKED;
                lock_pulse <= 1'b1;
                history    <= '0;
                fill       <= '0;
            end else if (unlock_event) begin
                state        <= ST_UNLOCKED;
                key_idx      <= key_sel;
                unlock_pulse <= 1'b1;
                history      <= '0;
                fill         <= '0;
            end else if (force_lock) begin
                history <= '0;
                fill    <= '0;
            end else if (accept) begin
                history <= history_shift;
                fill    <= fill_next;
            end
        end
    end

endmodule

// File: tb/tb_axis_key_unlocker.sv
// Directed bench for axis_key_unlocker: unlock keys, back-pressure, relock by sequence,
// idle timeout, force_lock and mid-sequence reset.
module tb_axis_key_unlocker;

    localparam logic [119:0] KEY0 = "#!manilamagic!#";
    localparam logic [119:0] KEY1 = "#!manilakey01!#";
    localparam logic [119:0] LOCK = "#!manilalock!!#";

    logic       clk;
    logic       sresetn;
    logic       s_axis_tready;
    logic       s_axis_tvalid;
    logic [7:0] s_axis_tdata;
    logic       m_axis_tready;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       force_lock;
    logic       unlocked;
    logic [0:0] key_idx;
    logic       unlock_pulse;
    logic       lock_pulse;

    int         checks = 0;
    int         failures = 0;
    int         mvalid_seen = 0;
    int         both_pulses = 0;
    logic [7:0] fwd[$];

    axis_key_unlocker #(
        .MAGIC_BYTES(15),
        .NUM_KEYS(2),
        .KEYS({KEY1, KEY0}),
        .LOCK_KEY(LOCK),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .sresetn(sresetn),
        .s_axis_tready(s_axis_tready),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .force_lock(force_lock),
        .unlocked(unlocked),
        .key_idx(key_idx),
        .unlock_pulse(unlock_pulse),
        .lock_pulse(lock_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedge observation: inputs are stable here, so this is exactly what the next edge transfers.
    always @(negedge clk) begin
        if (sresetn && m_axis_tvalid) mvalid_seen++;
        if (sresetn && m_axis_tvalid && m_axis_tready) fwd.push_back(m_axis_tdata);
        if (lock_pulse && unlock_pulse) both_pulses++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        @(negedge clk);
        while (!s_axis_tready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_wait: tready=%b required 1 within 50 cycles", s_axis_tready);
        end
        tick();
    endtask

    task automatic send_seq(input logic [119:0] seq, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(seq[119-8*i -: 8]);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        sresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hFF;
        m_axis_tready = 1'b1;
        force_lock    = 1'b0;
        repeat (3) tick();
        checks++;
        if (unlocked !== 1'b0 || key_idx !== 1'b0 || unlock_pulse !== 1'b0 || lock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: unl=%b idx=%b up=%b lp=%b required 0 0 0 0",
                     unlocked, key_idx, unlock_pulse, lock_pulse);
        end
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_outputs: srdy=%b mval=%b mdata=%h required 1 0 00",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata);
        end
        s_axis_tvalid = 1'b0;
        sresetn       = 1'b1;
        tick();
    endtask

    task automatic test_unlock_key0();
        mvalid_seen = 0;
        send_seq(KEY0, 0, 14);
        checks++;
        if (unlocked !== 1'b1 || unlock_pulse !== 1'b1 || key_idx !== 1'b0) begin
            failures++;
            $display("[TB] FAIL key0_unlock: unl=%b up=%b idx=%b required 1 1 0",
                     unlocked, unlock_pulse, key_idx);
        end
        tick();
        checks++;
        if (unlock_pulse !== 1'b0 || unlocked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL key0_pulse_width: up=%b unl=%b required 0 1", unlock_pulse, unlocked);
        end
        checks++;
        if (mvalid_seen !== 0) begin
            failures++;
            $display("[TB] FAIL key0_no_forward: m_valid cycles=%0d required 0", mvalid_seen);
        end
    endtask

    task automatic test_backpressure();
        fwd.delete();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA5) begin
                failures++;
                $display("[TB] FAIL bp_stall%0d: srdy=%b mval=%b mdata=%h required 0 1 a5",
                         i, s_axis_tready, m_axis_tvalid, m_axis_tdata);
            end
            tick();
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release: srdy=%b required 1", s_axis_tready);
        end
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        checks++;
        if (fwd.size() !== 1 || fwd[0] !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL bp_once: count=%0d required 1 byte a5", fwd.size());
        end
    endtask

    task automatic test_lock_key();
        logic [7:0] exp_b;
        fwd.delete();
        send_seq(LOCK, 0, 14);
        checks++;
        if (unlocked !== 1'b0 || lock_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lockkey_lock: unl=%b lp=%b required 0 1", unlocked, lock_pulse);
        end
        checks++;
        if (fwd.size() !== 15) begin
            failures++;
            $display("[TB] FAIL lockkey_count: forwarded=%0d required 15", fwd.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                exp_b = LOCK[119-8*i -: 8];
                checks++;
                if (fwd[i] !== exp_b) begin
                    failures++;
                    $display("[TB] FAIL lockkey_byte%0d: got %h required %h", i, fwd[i], exp_b);
                end
            end
        end
        tick();
        checks++;
        if (lock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lockkey_pulse_width: lp=%b required 0", lock_pulse);
        end
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h11;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lockkey_discard: srdy=%b mval=%b required 1 0", s_axis_tready, m_axis_tvalid);
        end
        tick();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_overlap_and_junk();
        send_byte(8'h23);
        send_seq(KEY0, 0, 14);
        checks++;
        if (unlocked !== 1'b1 || key_idx !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overlap_unlock: unl=%b idx=%b required 1 0", unlocked, key_idx);
        end
        force_lock = 1'b1;
        tick();
        force_lock = 1'b0;
        checks++;
        if (unlocked !== 1'b0 || lock_pulse !== 1'b1 || unlock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL force_relock: unl=%b lp=%b up=%b required 0 1 0",
                     unlocked, lock_pulse, unlock_pulse);
        end
        send_seq(KEY1, 0, 6);
        send_byte(8'h00);
        send_seq(KEY1, 7, 14);
        tick();
        checks++;
        if (unlocked !== 1'b0 || unlock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL junk_key1: unl=%b up=%b required 0 0", unlocked, unlock_pulse);
        end
        send_seq(KEY1, 0, 14);
        checks++;
        if (unlocked !== 1'b1 || key_idx !== 1'b1 || unlock_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL key1_unlock: unl=%b idx=%b up=%b required 1 1 1",
                     unlocked, key_idx, unlock_pulse);
        end
    endtask

    task automatic test_timeout();
        force_lock = 1'b1;
        tick();
        force_lock = 1'b0;
        send_seq(KEY0, 0, 14);
        repeat (99) tick();
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_99: unl=%b required 1", unlocked);
        end
        tick();
        checks++;
        if (unlocked !== 1'b0 || lock_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_100: unl=%b lp=%b required 0 1", unlocked, lock_pulse);
        end
        send_seq(KEY0, 0, 14);
        repeat (50) tick();
        send_byte(8'h5A);
        s_axis_tvalid = 1'b0;
        repeat (99) tick();
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_restart_99: unl=%b required 1", unlocked);
        end
        tick();
        checks++;
        if (unlocked !== 1'b0 || lock_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_restart_100: unl=%b lp=%b required 0 1", unlocked, lock_pulse);
        end
    endtask

    task automatic test_force_and_reset();
        send_seq(KEY0, 0, 14);
        send_seq(LOCK, 0, 13);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = LOCK[7:0];
        force_lock    = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        force_lock    = 1'b0;
        checks++;
        if (unlocked !== 1'b0 || lock_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lock_and_force: unl=%b lp=%b required 0 1", unlocked, lock_pulse);
        end
        tick();
        checks++;
        if (lock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lock_and_force_single: lp=%b required 0", lock_pulse);
        end
        send_seq(KEY0, 0, 13);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = KEY0[7:0];
        force_lock    = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        force_lock    = 1'b0;
        checks++;
        if (unlocked !== 1'b0 || unlock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL force_blocks_unlock: unl=%b up=%b required 0 0", unlocked, unlock_pulse);
        end
        tick();
        checks++;
        if (unlocked !== 1'b0 || unlock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL force_blocks_later: unl=%b up=%b required 0 0", unlocked, unlock_pulse);
        end
        send_seq(KEY0, 0, 6);
        sresetn = 1'b0;
        repeat (2) tick();
        sresetn = 1'b1;
        tick();
        send_seq(KEY0, 7, 14);
        checks++;
        if (unlocked !== 1'b0 || unlock_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_key: unl=%b up=%b required 0 0", unlocked, unlock_pulse);
        end
        send_seq(KEY0, 0, 14);
        checks++;
        if (unlocked !== 1'b1 || unlock_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_key_after_reset: unl=%b up=%b required 1 1", unlocked, unlock_pulse);
        end
    endtask

    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        m_axis_tready = 1'b1;
        force_lock    = 1'b0;
        sresetn       = 1'b0;
        test_reset();
        test_unlock_key0();
        test_backpressure();
        test_lock_key();
        test_overlap_and_junk();
        test_timeout();
        test_force_and_reset();
        checks++;
        if (both_pulses !== 0) begin
            failures++;
            $display("[TB] FAIL pulse_exclusive: overlap cycles=%0d required 0", both_pulses);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
